// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM multiplexed-address receiver.
package dram_pkg;

   localparam int unsigned MA_W   = 9;
   localparam int unsigned ADDR_W = 2 * MA_W;

   typedef enum logic [1:0] {
      StIdle,
      StRow,
      StPage,
      StCbr
   } dram_state_e;

   typedef struct packed {
      logic [MA_W-1:0] row;
      logic [MA_W-1:0] col;
   } dram_addr_t;

endpackage

// File: rtl/strobe_edge.sv
// Registered falling/rising edge detector for an active-low DRAM strobe pin.
module strobe_edge (
   input  logic clock_i,
   input  logic reset_i,
   input  logic sig_i,
   output logic level_o,
   output logic fall_o,
   output logic rise_o
);

   logic samp_q;
   logic hist_q;
   logic armed_q;

   // The sampler keeps tracking the pin through reset so that a strobe held low across
   // reset is already seen as low once the history register is back in use.
   always_ff @(posedge clock_i) begin
      samp_q <= sig_i;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         hist_q  <= 1'b1;
         armed_q <= 1'b0;
      end else begin
         hist_q  <= samp_q;
         armed_q <= 1'b1;
      end
   end

   assign level_o = samp_q;
   assign fall_o  = armed_q & hist_q & ~samp_q;
   assign rise_o  = armed_q & ~hist_q & samp_q;

endmodule

// File: rtl/dram_addr_demux.sv
// Rebuilds {row, col} from the time-multiplexed DRAM address lane and flags page hits,
// CAS-before-RAS refresh and strobe protocol violations.
module dram_addr_demux
   import dram_pkg::*;
(
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic [MA_W-1:0]   ma_i,
   input  logic              ras_l_i,
   input  logic              cas_l_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [MA_W-1:0]   row_o,
   output logic              strobe_o,
   output logic              page_hit_o,
   output logic              refresh_o,
   output logic              err_o,
   output logic              active_o
);

   dram_state_e     state_q, state_d;
   dram_addr_t      addr_q, addr_d;
   logic [MA_W-1:0] ma_q;
   logic            strobe_q, strobe_d;
   logic            page_hit_q, page_hit_d;
   logic            refresh_q, refresh_d;
   logic            err_q, err_d;

   logic ras_lvl_unused;
   logic ras_fall, ras_rise;
   logic cas_lvl, cas_fall, cas_rise_unused;

   strobe_edge u_ras_edge (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .sig_i   (ras_l_i),
      .level_o (ras_lvl_unused),
      .fall_o  (ras_fall),
      .rise_o  (ras_rise)
   );

   strobe_edge u_cas_edge (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .sig_i   (cas_l_i),
      .level_o (cas_lvl),
      .fall_o  (cas_fall),
      .rise_o  (cas_rise_unused)
   );

   // Address lane is sampled alongside the strobes so it lines up with the detected edge.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         ma_q <= '0;
      end else begin
         ma_q <= ma_i;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      strobe_d   = 1'b0;
      page_hit_d = 1'b0;
      refresh_d  = 1'b0;
      err_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ras_fall) begin
               if (!cas_lvl) begin
                  refresh_d = 1'b1;
                  state_d   = StCbr;
               end else begin
                  addr_d.row = ma_q;
                  state_d    = StRow;
               end
            end else if (cas_fall) begin
               err_d = 1'b1;
            end
         end
         StRow, StPage: begin
            // A RAS rise closes the cycle; a CAS fall in the same sample is a violation.
            if (ras_rise) begin
               err_d   = cas_fall;
               state_d = StIdle;
            end else if (cas_fall) begin
               addr_d.col = ma_q;
               strobe_d   = 1'b1;
               page_hit_d = (state_q == StPage);
               state_d    = StPage;
            end
         end
         StCbr: begin
            err_d = cas_fall;
            if (ras_rise) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         strobe_q   <= 1'b0;
         page_hit_q <= 1'b0;
         refresh_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         strobe_q   <= strobe_d;
         page_hit_q <= page_hit_d;
         refresh_q  <= refresh_d;
         err_q      <= err_d;
      end
   end

   assign addr_o     = addr_q;
   assign row_o      = addr_q.row;
   assign strobe_o   = strobe_q;
   assign page_hit_o = page_hit_q;
   assign refresh_o  = refresh_q;
   assign err_o      = err_q;
   assign active_o   = (state_q == StRow) || (state_q == StPage);

endmodule

// File: tb/tb_dram_addr_demux.sv
// Bench for dram_addr_demux: transaction-level expectations ({row, col} = row*512 + col).
module tb_dram_addr_demux;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [8:0]  ma    = '0;
   logic        ras_l = 1'b1;
   logic        cas_l = 1'b1;
   logic [17:0] addr;
   logic [8:0]  row;
   logic        strobe, page_hit, refresh, err, active;

   int vectors     = 0;
   int miscompares = 0;
   int strobe_cnt  = 0;
   int refresh_cnt = 0;
   int err_cnt     = 0;
   bit refresh_prev = 1'b0;
   bit err_prev     = 1'b0;

   int         obs_addr[$];
   bit         obs_ph[$];
   int         exp_addr[$];
   bit         exp_ph[$];
   logic [8:0] col_list[$];

   always #5 clock = ~clock;

   dram_addr_demux dut (
      .clock_i    (clock),
      .reset_i    (reset),
      .ma_i       (ma),
      .ras_l_i    (ras_l),
      .cas_l_i    (cas_l),
      .addr_o     (addr),
      .row_o      (row),
      .strobe_o   (strobe),
      .page_hit_o (page_hit),
      .refresh_o  (refresh),
      .err_o      (err),
      .active_o   (active)
   );

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Collects strobed addresses and pulse counts; page_hit only with strobe, pulses single-cycle.
   always @(negedge clock) begin
      if (!reset) begin
         if (strobe) begin
            obs_addr.push_back(int'(addr));
            obs_ph.push_back(page_hit);
            strobe_cnt++;
         end
         if (refresh) refresh_cnt++;
         if (err) err_cnt++;
         vectors++;
         if ((page_hit && !strobe) || (refresh && refresh_prev) || (err && err_prev)) begin
            miscompares++;
            $display("FAIL pulse_rules: strobe=%0b page_hit=%0b refresh=%0b(prev %0b) err=%0b(prev %0b), required page_hit only with strobe and single-cycle pulses",
                     strobe, page_hit, refresh, refresh_prev, err, err_prev);
         end
         refresh_prev = refresh;
         err_prev     = err;
      end
   end

   task automatic run_access(input logic [8:0] r);
      ma = r; ras_l = 1'b0;
      cyc(2);
      for (int i = 0; i < col_list.size(); i++) begin
         ma = col_list[i]; cas_l = 1'b0;
         cyc(2);
         cas_l = 1'b1;
         cyc(2);
         exp_addr.push_back(int'(r) * 512 + int'(col_list[i]));
         exp_ph.push_back(i > 0);
      end
      ras_l = 1'b1;
      cyc(3);
   endtask

   task automatic test_reset();
      reset = 1'b1; ras_l = 1'b1; cas_l = 1'b1;
      cyc(3);
      @(negedge clock);
      vectors++;
      if ({addr, row} !== 27'd0) begin
         miscompares++;
         $display("FAIL reset_addr: addr=%h row=%h, required 0", addr, row);
      end
      vectors++;
      if ({strobe, page_hit, refresh, err, active} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_flags: %b, required 00000", {strobe, page_hit, refresh, err, active});
      end
      @(posedge clock); #1;
      reset = 1'b0;
      cyc(2);
   endtask

   task automatic test_single();
      int s0;
      s0 = strobe_cnt;
      ma = 9'h1A5; ras_l = 1'b0;
      @(posedge clock); @(negedge clock);
      vectors++;
      if (active !== 1'b0) begin
         miscompares++; $display("FAIL single_active_early: got %b, required 0", active);
      end
      @(posedge clock); @(negedge clock);
      vectors++;
      if (active !== 1'b1) begin
         miscompares++; $display("FAIL single_active_open: got %b, required 1", active);
      end
      @(posedge clock); #1;
      ma = 9'h03C; cas_l = 1'b0;
      @(posedge clock); @(negedge clock);
      vectors++;
      if (strobe !== 1'b0) begin
         miscompares++; $display("FAIL single_strobe_early: got %b, required 0", strobe);
      end
      @(posedge clock); @(negedge clock);
      vectors++;
      if (strobe !== 1'b1 || addr !== 18'h34A3C || page_hit !== 1'b0 || row !== 9'h1A5) begin
         miscompares++;
         $display("FAIL single_strobe: strobe=%b addr=%h page_hit=%b row=%h, required 1 34a3c 0 1a5",
                  strobe, addr, page_hit, row);
      end
      @(posedge clock); @(negedge clock);
      vectors++;
      if (strobe !== 1'b0) begin
         miscompares++; $display("FAIL single_strobe_width: got %b, required 0", strobe);
      end
      @(posedge clock); #1;
      cas_l = 1'b1; ras_l = 1'b1;
      @(posedge clock); @(negedge clock);
      vectors++;
      if (active !== 1'b1) begin
         miscompares++; $display("FAIL single_active_late: got %b, required 1", active);
      end
      @(posedge clock); @(negedge clock);
      vectors++;
      if (active !== 1'b0) begin
         miscompares++; $display("FAIL single_active_closed: got %b, required 0", active);
      end
      cyc(2);
      vectors++;
      if (strobe_cnt - s0 != 1) begin
         miscompares++; $display("FAIL single_count: %0d strobes, required 1", strobe_cnt - s0);
      end
   endtask

   task automatic test_page_mode();
      obs_addr.delete(); obs_ph.delete(); exp_addr.delete(); exp_ph.delete();
      col_list = '{9'h001, 9'h002, 9'h1FF};
      run_access(9'h0FF);
      vectors++;
      if (obs_addr.size() != exp_addr.size()) begin
         miscompares++;
         $display("FAIL page_count: %0d strobes, required %0d", obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
         vectors++;
         if (obs_addr[i] !== exp_addr[i] || obs_ph[i] !== exp_ph[i]) begin
            miscompares++;
            $display("FAIL page_access[%0d]: addr=%h hit=%b, required addr=%h hit=%b",
                     i, obs_addr[i], obs_ph[i], exp_addr[i], exp_ph[i]);
         end
      end
   endtask

   task automatic test_random_access();
      obs_addr.delete(); obs_ph.delete(); exp_addr.delete(); exp_ph.delete();
      for (int t = 0; t < 12; t++) begin
         int n;
         logic [8:0] r;
         r = 9'($urandom_range(0, 511));
         n = $urandom_range(1, 4);
         col_list.delete();
         for (int k = 0; k < n; k++) col_list.push_back(9'($urandom_range(0, 511)));
         run_access(r);
      end
      vectors++;
      if (obs_addr.size() != exp_addr.size()) begin
         miscompares++;
         $display("FAIL random_count: %0d strobes, required %0d", obs_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
         vectors++;
         if (obs_addr[i] !== exp_addr[i] || obs_ph[i] !== exp_ph[i]) begin
            miscompares++;
            $display("FAIL random_access[%0d]: addr=%h hit=%b, required addr=%h hit=%b",
                     i, obs_addr[i], obs_ph[i], exp_addr[i], exp_ph[i]);
         end
      end
   endtask

   task automatic test_cbr();
      int r0, s0, e0;
      logic [8:0] row0;
      cas_l = 1'b0;
      cyc(3);
      row0 = row; r0 = refresh_cnt; s0 = strobe_cnt; e0 = err_cnt;
      ma = 9'h155; ras_l = 1'b0;
      cyc(4);
      vectors++;
      if (refresh_cnt - r0 != 1 || err_cnt != e0 || strobe_cnt != s0) begin
         miscompares++;
         $display("FAIL cbr_seq: refresh=%0d err=%0d strobe=%0d, required 1 0 0",
                  refresh_cnt - r0, err_cnt - e0, strobe_cnt - s0);
      end
      vectors++;
      if (row !== row0 || active !== 1'b0) begin
         miscompares++;
         $display("FAIL cbr_row: row=%h active=%b, required row=%h active=0", row, active, row0);
      end
      e0 = err_cnt;
      cas_l = 1'b1; cyc(2);
      cas_l = 1'b0; cyc(3);
      vectors++;
      if (err_cnt - e0 != 1) begin
         miscompares++; $display("FAIL cbr_cas_err: %0d err pulses, required 1", err_cnt - e0);
      end
      ras_l = 1'b1; cas_l = 1'b1;
      cyc(3);
      r0 = refresh_cnt; e0 = err_cnt; s0 = strobe_cnt;
      ras_l = 1'b0; cas_l = 1'b0;
      cyc(4);
      vectors++;
      if (refresh_cnt - r0 != 1 || err_cnt != e0 || strobe_cnt != s0 || row !== row0) begin
         miscompares++;
         $display("FAIL cbr_simul: refresh=%0d err=%0d strobe=%0d row=%h, required 1 0 0 %h",
                  refresh_cnt - r0, err_cnt - e0, strobe_cnt - s0, row, row0);
      end
      ras_l = 1'b1; cyc(2);
      cas_l = 1'b1; cyc(2);
   endtask

   task automatic test_violation();
      int s0, e0;
      s0 = strobe_cnt; e0 = err_cnt;
      cas_l = 1'b0; cyc(2);
      cas_l = 1'b1; cyc(3);
      vectors++;
      if (err_cnt - e0 != 1 || strobe_cnt != s0) begin
         miscompares++;
         $display("FAIL viol_cas_only: err=%0d strobe=%0d, required 1 0", err_cnt - e0, strobe_cnt - s0);
      end
      ma = 9'($urandom_range(0, 511)); ras_l = 1'b0;
      cyc(3);
      s0 = strobe_cnt; e0 = err_cnt;
      ras_l = 1'b1; cas_l = 1'b0;
      cyc(3);
      vectors++;
      if (err_cnt - e0 != 1 || strobe_cnt != s0 || active !== 1'b0) begin
         miscompares++;
         $display("FAIL viol_rise_fall: err=%0d strobe=%0d active=%b, required 1 0 0",
                  err_cnt - e0, strobe_cnt - s0, active);
      end
      cas_l = 1'b1; cyc(2);
   endtask

   task automatic test_reset_mid();
      int s0, e0;
      logic [8:0] r, c;
      ma = 9'($urandom_range(0, 511)); ras_l = 1'b0;
      cyc(3);
      reset = 1'b1;
      cyc(2);
      @(negedge clock);
      vectors++;
      if ({addr, row, strobe, page_hit, refresh, err, active} !== 32'd0) begin
         miscompares++;
         $display("FAIL mid_reset_clear: addr=%h row=%h flags=%b, required all 0",
                  addr, row, {strobe, page_hit, refresh, err, active});
      end
      @(posedge clock); #1;
      reset = 1'b0;
      cyc(3);
      vectors++;
      if (active !== 1'b0) begin
         miscompares++; $display("FAIL mid_idle: active=%b, required 0", active);
      end
      s0 = strobe_cnt; e0 = err_cnt;
      cas_l = 1'b0;
      cyc(3);
      vectors++;
      if (err_cnt - e0 != 1 || strobe_cnt != s0) begin
         miscompares++;
         $display("FAIL mid_cas: err=%0d strobe=%0d, required 1 0", err_cnt - e0, strobe_cnt - s0);
      end
      cas_l = 1'b1; ras_l = 1'b1;
      cyc(3);
      obs_addr.delete(); obs_ph.delete(); exp_addr.delete(); exp_ph.delete();
      r = 9'($urandom_range(0, 511));
      c = 9'($urandom_range(0, 511));
      col_list = '{c};
      run_access(r);
      vectors++;
      if (obs_addr.size() != 1 || obs_addr[0] !== int'(r) * 512 + int'(c) || obs_ph[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_recover: %0d strobes first=%h, required 1 strobe addr=%h hit=0",
                  obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : -1, int'(r) * 512 + int'(c));
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_page_mode();
      test_random_access();
      test_cbr();
      test_violation();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dram_addr_demux.md
Name: dram_addr_demux

Overview:
- Receiving end of the time-multiplexed DRAM address lane that the 2:1 address muxes drive.
- Samples the shared MA lane on the falling edges of RAS_L and CAS_L and rebuilds the full row/column address.
- Emits one registered access strobe per CAS cycle, and flags page-mode hits and CAS-before-RAS refresh.
- Sits beside the DRAM model and the bus monitor; consumes only pins that the memory controller already drives.

Parameters:
- MA_W, 9, width of the multiplexed address lane.
- ADDR_W, 2*MA_W (18), reconstructed address width, laid out as {row, col}.

Ports:
- clock  in  1  system clock; every input is sampled on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ma  in  MA_W  multiplexed address lane.
- ras_l  in  1  row strobe, active low.
- cas_l  in  1  column strobe, active low.
- addr  out  ADDR_W  last reconstructed address, {row_q, col_q}.
- row  out  MA_W  latched row.
- strobe  out  1  one-cycle pulse when addr is valid for a new access.
- page_hit  out  1  qualifies strobe: second or later CAS within one RAS.
- refresh  out  1  one-cycle pulse on detection of a CAS-before-RAS refresh.
- err  out  1  one-cycle pulse on a protocol violation.
- active  out  1  high while a RAS cycle is open (states ROW or PAGE).

Behaviour:
- Reset values: all outputs 0, row and col registers 0, state IDLE, edge-detect history registers 1 (inactive).
- Edge detect: ras_fall = ras_q & ~ras_l, where ras_q is the previous sample. Define ras_rise, cas_fall and cas_rise the same way.
- States:
  - IDLE: no RAS cycle open.
  - ROW: RAS cycle open, no CAS seen yet.
  - PAGE: RAS cycle open, at least one CAS seen.
  - CBR: refresh in progress.
- From IDLE:
  - ras_fall with cas_l=1: latch row_q<=ma, go to ROW.
  - ras_fall with cas_l=0: CAS-before-RAS refresh. Pulse refresh, go to CBR, row_q unchanged.
  - cas_fall with ras_l=1: pulse err, stay in IDLE.
- From ROW or PAGE:
  - cas_fall: latch col_q<=ma and pulse strobe on the next cycle.
    - page_hit=0 on the first CAS (ROW→PAGE), 1 on later CAS (stay in PAGE).
  - ras_rise: go to IDLE, even if CAS is still low.
- From CBR: ras_rise goes to IDLE. Any cas_fall while in CBR pulses err.
- Latency: strobe, addr and page_hit update exactly 1 clock after the cycle in which cas_fall is detected. Total is 2 clocks from the pin edge.
- Simultaneous events:
  - ras_rise and cas_fall in the same sample: ras_rise wins. No strobe, err pulses, go to IDLE.
  - ras_fall and cas_fall in the same sample from IDLE: treat as refresh (CBR).
- page_hit is valid only while strobe=1 and is 0 otherwise.
- strobe, refresh and err are never high for more than one cycle per event.
- Reset asserted mid-cycle: return to IDLE at once, with all pulses and latches cleared. History registers go to 1, so a strobe held low across reset produces no edge. The first access after reset needs a fresh RAS fall.

Decomposition:
- Shared package dram_pkg:
  - typedef of the state enum (IDLE, ROW, PAGE, CBR).
  - constant MA_W.
  - packed struct for {row, col}.
- One sub-module, strobe_edge: 1-bit registered falling/rising edge detector with reset value 1. Instantiate it twice, once for ras_l and once for cas_l.

Test Plan:
- Single access: ma=0x1A5, ras_l falls; ma=0x03C, cas_l falls; both rise.
  - Expect one strobe 2 clocks after the CAS fall, addr=0x34A3C, page_hit=0, active high from the cycle after the RAS fall until the cycle after the RAS rise.
- Page mode: row 0x0FF, then three CAS pulses with cols 0x001, 0x002, 0x1FF.
  - Expect three strobes with addr 0x1FE01, 0x1FE02, 0x1FFFF and page_hit 0, 1, 1.
- CBR refresh: cas_l low, then ras_l falls.
  - Expect refresh pulse of exactly 1 cycle, no strobe, row unchanged, err=0.
- Violations:
  - CAS pulse with RAS high: err pulses once, strobe stays 0.
  - ras_rise and cas_fall in the same sample: err pulses, no strobe, state returns to IDLE.
- Reset mid-access: assert reset after the RAS fall, before the CAS fall; release reset with ras_l still low, then cas_l falls.
  - Expect no strobe and an err pulse, because the state is IDLE.
  - A following full RAS/CAS cycle decodes correctly.
